// File: rtl/add_32_serial.sv
// -----------------------------------------------------------------------------
// add_32_serial
//
// Multi-cycle adder for the ALU path where a single-cycle WIDTH-bit carry
// chain does not close timing. An accepted start latches both operands and the
// carry-in. One SLICE-bit slice is then added per clock, least significant
// slice first. The carry between slices is held in a register. After NSLICE
// add cycles the sum and flags are presented together with a one-cycle done
// pulse. They hold until the next accepted start.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request; sampled only in IDLE or in the DONE cycle
//   cin       carry into bit 0, latched on accepted start
//   in0, in1  operands A and B, latched on accepted start
//   busy      high while slices are being added
//   done      single-cycle pulse; out and flags valid
//   out       A + B + cin mod 2^WIDTH (partial while busy)
//   carryout  carry out of bit WIDTH-1
//   overflow  signed two's-complement overflow
//   zero      high when out == 0
// -----------------------------------------------------------------------------
module add_32_serial #(
    parameter int WIDTH = 32,   // must be an integer multiple of SLICE
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_d;
    logic             busy_d, done_d, carryout_d, overflow_d, zero_d;

    logic             load;
    logic [SLICE-1:0] a_slice, b_slice;
    logic [SLICE:0]   slice_sum;    // {carry, sum} of the current slice
    logic [WIDTH-1:0] out_merged;   // out with the current slice written in

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so that
        // no path leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        k_d        = k_q;
        out_d      = out;
        busy_d     = busy;
        done_d     = 1'b0;
        carryout_d = carryout;
        overflow_d = overflow;
        zero_d     = zero;

        a_slice    = a_q[k_q*SLICE +: SLICE];
        b_slice    = b_q[k_q*SLICE +: SLICE];
        slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
        out_merged = out;
        out_merged[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];

        // A start is accepted from IDLE and from the DONE cycle (back-to-back).
        load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                out_d   = out_merged;
                carry_d = slice_sum[SLICE];
                if (k_q == K_LAST) begin
                    // The final slice holds the sign bit of the result.
                    carryout_d = slice_sum[SLICE];
                    overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (slice_sum[SLICE-1] != a_q[WIDTH-1]);
                    zero_d     = (out_merged == '0);
                    k_d        = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accepting a start clears the previous result and its flags.
        if (load) begin
            a_d        = in0;
            b_d        = in1;
            carry_d    = cin;
            k_d        = '0;
            out_d      = '0;
            carryout_d = 1'b0;
            overflow_d = 1'b0;
            zero_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = S_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every register, including the operand latches, is reset so that
    // no X can reach the outputs after reset, even mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            out      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so that every register samples
            // the values from before the edge regardless of statement order.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            k_q      <= k_d;
            out      <= out_d;
            busy     <= busy_d;
            done     <= done_d;
            carryout <= carryout_d;
            overflow <= overflow_d;
            zero     <= zero_d;
        end
    end

endmodule

// File: tb/tb_add_32_serial.sv
// -----------------------------------------------------------------------------
// tb_add_32_serial
//
// Bench for add_32_serial. The stimulus pushes the expected result of each
// accepted operation into a queue. A negedge monitor pops one entry per done
// pulse. It compares the sum, the flags and the start-to-done latency.
// -----------------------------------------------------------------------------
module tb_add_32_serial;

    localparam int WIDTH  = 32;
    localparam int NSLICE = 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] in0   = '0;
    logic [WIDTH-1:0] in1   = '0;
    logic             busy, done, carryout, overflow, zero;
    logic [WIDTH-1:0] out;

    add_32_serial #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cin      (cin),
        .in0      (in0),
        .in1      (in1),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .carryout (carryout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ov;
        logic             z;
        int               acc;   // cycle count just after the accepting edge
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    logic done_prev = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c);
        exp_t            e;
        longint unsigned u;
        longint          sa, sb_, s;
        u  = 64'(a) + 64'(b) + 64'(c);
        sa = $signed(a);
        sb_ = $signed(b);
        s  = sa + sb_ + longint'(c);
        e.sum = u[WIDTH-1:0];
        e.co  = u[WIDTH];
        e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.z   = (e.sum == '0);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: one scoreboard entry per done pulse.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("done_single_pulse", done_prev, 0);
            if (sb.size() == 0) begin
                fail("unexpected_done");
            end else begin
                mon_e = sb.pop_front();
                check("out",      out,      mon_e.sum);
                check("carryout", carryout, mon_e.co);
                check("overflow", overflow, mon_e.ov);
                check("zero",     zero,     mon_e.z);
                check("latency",  cyc - mon_e.acc, NSLICE);
                check("busy_at_done", busy, 0);
            end
        end
        done_prev = done;
    end

    // Drives start from the current time (caller sits at a negedge), records
    // the accepting edge, then drops start and scrambles the operand inputs.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input bit push);
        exp_t e;
        in0   = a;
        in1   = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e     = model(a, b, c);
            e.acc = cyc;
            sb.push_back(e);
            n_pushed++;
        end
        check("busy_after_start", busy, 1);
        check("out_cleared", {out, carryout, overflow, zero}, 0);
        @(negedge clk);
        start = 1'b0;
        in0   = $urandom;
        in1   = $urandom;
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Returns at the negedge where done is high (the DONE cycle).
    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        fail("done_timeout");
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        issue(a, b, c, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic             c;
        exp_t             e;

        // Reset state
        #1;
        check("reset_busy_done", {busy, done}, 0);
        check("reset_out_flags", {out, carryout, overflow, zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);   @(negedge clk);
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);   @(negedge clk);
        op(32'h0000_00FF, 32'h0000_0000, 1'b1);   @(negedge clk);
        op(32'h00FF_FFFF, 32'h0000_0001, 1'b0);   @(negedge clk);
        op(32'h8000_0000, 32'h8000_0000, 1'b0);   @(negedge clk);

        // Start asserted with changed operands during RUN cycles 1-3 is ignored
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            in0   = $urandom;
            in1   = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();

        // Back-to-back: start in the DONE cycle
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done();
        repeat (6) @(negedge clk);

        // Asynchronous reset after two slices
        a = $urandom;
        b = $urandom;
        c = 1'($urandom_range(0, 1));
        e = model(a, b, c);
        issue(a, b, c, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("partial_low_slices", out, e.sum & 32'h0000_FFFF);
        check("busy_mid_run", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy_done", {busy, done}, 0);
        check("async_rst_out_flags", {out, carryout, overflow, zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        op(32'h0000_0005, 32'h0000_0003, 1'b0);
        @(negedge clk);

        // Randomized operations, alternating idle gaps and back-to-back starts
        for (int i = 0; i < 24; i++) begin
            case (i % 6)
                0:       begin a = $urandom; b = ~a;             end
                1:       begin a = 32'h7FFF_FFFF; b = $urandom;  end
                default: begin a = $urandom; b = $urandom;       end
            endcase
            op(a, b, 1'($urandom_range(0, 1)));
            if (i % 2 == 0) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_32_serial.md
Name: add_32_serial

Overview:
- Multi-cycle 32-bit adder: latches two operands and a carry-in, then adds one 8-bit slice per clock, least significant slice first, through a registered carry chain.
- Counterpart to the combinational 32-bit subtractor (sub_32) in the ALU datapath: it performs the inverse operation, addition, with the same 8-bit slice structure.
- Used by the multi-cycle ALU path where a single-cycle 32-bit carry chain does not meet timing.
- Also reports carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits added per clock.
- NSLICE, WIDTH/SLICE (derived, localparam), number of add cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or in the DONE cycle.
- cin  input  1  carry into bit 0; latched on accepted start.
- in0  input  WIDTH  operand A; latched on accepted start.
- in1  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while slices are being added.
- done  output  1  single-cycle pulse; result and flags valid.
- out  output  WIDTH  sum A+B+cin mod 2^WIDTH.
- carryout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  high when out == 0.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; busy, done, out, carryout, overflow and zero all 0; operand, carry and slice-counter registers all 0. Takes effect immediately, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch in0, in1 and cin (carry register <= cin);
  - slice counter k <= 0; out <= 0;
  - busy <= 1; go to RUN.
- RUN, each edge:
  - {c, s} = A[k*SLICE +: SLICE] + B[k*SLICE +: SLICE] + carry (SLICE+1 bits);
  - out[k*SLICE +: SLICE] <= s; carry <= c; k <= k+1.
- RUN, final slice (k = NSLICE-1), at that same edge:
  - carryout <= c;
  - overflow <= (A[WIDTH-1] == B[WIDTH-1]) && (s[SLICE-1] != A[WIDTH-1]);
  - zero <= (full result including the final slice == 0);
  - busy <= 0; done <= 1; go to DONE.
- Latency: start sampled at E0, done high in the cycle after edge E_NSLICE (E4 for the defaults).
- DONE (one cycle):
  - done <= 0 at the next edge.
  - If start=1 in this cycle, it is accepted exactly as from IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Result hold: out, carryout, overflow and zero hold their values from the done cycle until the next accepted start. At that start, out and the flags clear to 0.
- While busy: out is partial; lower slices are final, upper slices are 0. Consumers must use out only at or after done.
- start during RUN is ignored, with no effect on the operation or the latched operands. Operand changes after the accepting edge are ignored.
- Full wrap-around: 0xFFFFFFFF + 0xFFFFFFFF + 1 gives out=0xFFFFFFFF, carryout=1.
- No X propagation: all state registers are reset. k never exceeds NSLICE-1.

Test Plan:
- in0=0x00000001, in1=0xFFFFFFFF, cin=0, pulse start -> done exactly 4 cycles after start edge; out=0x00000000, carryout=1, overflow=0, zero=1.
- in0=0x7FFFFFFF, in1=0x00000001, cin=0 -> out=0x80000000, carryout=0, overflow=1, zero=0.
- in0=0x000000FF, in1=0x00000000, cin=1 -> out=0x00000100, confirming carry between slices. Then in0=0x00FFFFFF, in1=0x00000001, cin=0 -> out=0x01000000.
- Start 0x11111111+0x22222222; assert start again, with in0/in1 changed, on cycles 1-3 of RUN -> ignored; out=0x33333333, one done pulse only.
- Assert start in the DONE cycle with 0xFFFFFFFF+0xFFFFFFFF, cin=1 -> accepted without an idle cycle; second done 4 cycles later; out=0xFFFFFFFF, carryout=1, overflow=0.
- Assert rst asynchronously after 2 slices -> busy, done, out and flags drop to 0 immediately; no done pulse. After release, 0x00000005+0x00000003 -> out=0x00000008 after 4 cycles.
